// File: rtl/ram_pkg.sv
// Shared types and constants for the single-port RAM controller.
// Provides FSM state encoding, the read-latency ceiling and the byte-lane width helper.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int MAX_RD_LAT = 3;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Raw DEPTH x DATA_W storage with byte-enable write and a registered read.
// Ports: i_clk, i_rst_n (read register only), i_we/i_be/i_wdata write,
//        i_re read strobe, i_addr shared address, o_rdata registered read data.
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_we,
    input  logic                      i_re,
    input  logic [be_w(DATA_W)-1:0]   i_be,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    output logic [DATA_W-1:0]         o_rdata
);

    localparam int BE_W  = be_w(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Only loads on a read, so it also acts as the held output for latency 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: req/ready handshake, byte writes, read pipeline,
// clear engine. Ports: i_clk, i_rst_n, i_req, i_we, i_be, i_addr, i_d_in, i_clr;
// o_ready, o_d_out, o_rd_valid, o_clr_busy.
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req,
    input  logic                      i_we,
    input  logic [be_w(DATA_W)-1:0]   i_be,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_d_in,
    input  logic                      i_clr,
    output logic                      o_ready,
    output logic [DATA_W-1:0]         o_d_out,
    output logic                      o_rd_valid,
    output logic                      o_clr_busy
);

    localparam int BE_W = be_w(DATA_W);
    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT || (DATA_W % 8) != 0) begin : g_bad_cfg
        $error("ram_sp_ctrl: RD_LAT must be 1..3 and DATA_W a multiple of 8");
    end

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_cnt;
    logic                r_ready;
    logic                r_start;

    logic                w_acc;
    logic                w_mem_we;
    logic                w_mem_re;
    logic [BE_W-1:0]     w_mem_be;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0]   w_rdata;

    // ready is registered so it is low throughout reset and the release cycle.
    assign w_acc      = i_req & r_ready;
    assign o_ready    = r_ready;
    assign o_clr_busy = (r_state == ST_CLEAR);

    always_comb begin
        w_next      = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_be    = i_be;
        w_mem_addr  = i_addr;
        w_mem_wdata = i_d_in;
        unique case (r_state)
            ST_IDLE: begin
                w_mem_we = w_acc & i_we;
                w_mem_re = w_acc & ~i_we;
                // r_start forces the post-reset clear on the first edge.
                if (i_clr || r_start) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_be    = '1;
                w_mem_addr  = r_cnt[ADDR_W-1:0];
                w_mem_wdata = '0;
                if (r_cnt[ADDR_W-1:0] == LAST) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_start <= (CLR_ON_RST != 0);
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
            r_start <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_be    (w_mem_be),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_rdata)
    );

    // The array register is the first read stage; extra stages follow it.
    if (RD_LAT == 1) begin : g_lat1
        logic r_vld;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld <= 1'b0;
            end else begin
                r_vld <= w_mem_re;
            end
        end

        assign o_rd_valid = r_vld;
        assign o_d_out    = w_rdata;
    end else begin : g_latn
        logic [RD_LAT-1:0] r_vld;
        logic [DATA_W-1:0] r_dat [RD_LAT-1];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld <= '0;
                for (int k = 0; k < RD_LAT-1; k++) begin
                    r_dat[k] <= '0;
                end
            end else begin
                r_vld <= {r_vld[RD_LAT-2:0], w_mem_re};
                // Stages load only behind a valid, so the last one holds d_out.
                if (r_vld[0]) begin
                    r_dat[0] <= w_rdata;
                end
                for (int k = 1; k < RD_LAT-1; k++) begin
                    if (r_vld[k]) begin
                        r_dat[k] <= r_dat[k-1];
                    end
                end
            end
        end

        assign o_rd_valid = r_vld[RD_LAT-1];
        assign o_d_out    = r_dat[RD_LAT-2];
    end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Scoreboard bench for ram_sp_ctrl with an array-level reference model.
// Driver pushes expected read results; a negedge monitor pops and compares.
module tb_ram_sp_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 3;

    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] d_in;
    logic          clr;
    logic          ready;
    logic [DW-1:0] d_out;
    logic          rd_valid;
    logic          clr_busy;

    int            n_tests;
    int            n_fail;
    int            cyc;
    int            last_wait;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] last_dout;
    exp_t          q[$];

    ram_sp_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .RD_LAT     (LAT),
        .CLR_ON_RST (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_we       (we),
        .i_be       (be),
        .i_addr     (addr),
        .i_d_in     (d_in),
        .i_clr      (clr),
        .o_ready    (ready),
        .o_d_out    (d_out),
        .o_rd_valid (rd_valid),
        .o_clr_busy (clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no rd_valid", d_out);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("rd_data", int'(d_out), int'(x.d));
                    check("rd_cycle", cyc, x.e);
                end
                last_dout = d_out;
            end else begin
                check("d_out_hold", int'(d_out), int'(last_dout));
            end
        end else begin
            last_dout = '0;
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endfunction

    // Entered and left at a negedge; holds the request until ready.
    task automatic do_req(input logic w, input logic [1:0] b, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic c);
        int k;
        k = 0;
        req = 1'b1; we = w; be = b; addr = a; d_in = d; clr = c;
        while (!ready && k < 600) begin
            @(negedge clk);
            clr = 1'b0;
            k++;
        end
        last_wait = k;
        if (!ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got ready=0 expected ready=1");
        end else begin
            if (w) begin
                for (int i = 0; i < 2; i++) begin
                    if (b[i]) mem[a][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                exp_t x;
                x.d = mem[a];
                x.e = cyc + LAT;
                q.push_back(x);
            end
            if (clr) model_clear();
        end
        @(negedge clk);
        req = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        if (ready) model_clear();
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Counts cycles with clr_busy high; optionally pulses clr at cycle pulse_at.
    task automatic count_busy(input string name, input int pulse_at);
        int n;
        int w;
        int bad;
        n = 0; w = 0; bad = 0;
        while (!clr_busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        while (clr_busy && n < 1000) begin
            if (ready) bad++;
            clr = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        clr = 1'b0;
        check({name, "_len"}, n, 256);
        check({name, "_ready_low"}, bad, 0);
        check({name, "_ready_after"}, int'(ready), 1);
    endtask

    task automatic reset_checks(input string name);
        check({name, "_ready"}, int'(ready), 0);
        check({name, "_rd_valid"}, int'(rd_valid), 0);
        check({name, "_clr_busy"}, int'(clr_busy), 0);
        check({name, "_d_out"}, int'(d_out), 0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_dout = '0;
        req = 0; we = 0; be = 0; addr = 0; d_in = 0; clr = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        model_clear();

        // 1: post-reset clear, then boundary addresses read zero
        count_busy("boot_clear", -1);
        do_req(0, 2'b00, 8'h00, 16'h0, 0);
        do_req(0, 2'b00, 8'hFF, 16'h0, 0);

        // 2: byte enables
        do_req(1, 2'b11, 8'h10, 16'hA5A5, 0);
        do_req(1, 2'b10, 8'h10, 16'h3C00, 0);
        do_req(0, 2'b00, 8'h10, 16'h0, 0);
        do_req(1, 2'b00, 8'h10, 16'hFFFF, 0);
        do_req(0, 2'b00, 8'h10, 16'h0, 0);

        // 3: back-to-back reads
        for (int i = 1; i <= 3; i++) do_req(1, 2'b11, 8'(i), 16'(i), 0);
        for (int i = 1; i <= 3; i++) do_req(0, 2'b00, 8'(i), 16'h0, 0);

        // 4: clr with a write; a held read waits out the whole clear
        do_req(1, 2'b11, 8'h20, 16'hBEEF, 1);
        check("clr_busy_rise", int'(clr_busy), 1);
        do_req(0, 2'b00, 8'h20, 16'h0, 0);
        check("held_req_wait", last_wait, 256);

        // clr during a clear does not restart it
        pulse_clr();
        count_busy("clr_ignored", 50);

        // 6: read in flight when clear starts keeps pre-clear data
        do_req(1, 2'b11, 8'h30, 16'h1234, 0);
        do_req(0, 2'b00, 8'h30, 16'h0, 0);
        pulse_clr();
        count_busy("clr_after_rd", -1);
        do_req(0, 2'b00, 8'h30, 16'h0, 0);

        // 5: reset mid-clear at count 100
        pulse_clr();
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("mid_clr_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("rst_clear", -1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_clr();
            end else if (r < 8) begin
                @(negedge clk);
            end else begin
                do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       8'($urandom_range(0, 15)), 16'($urandom),
                       1'($urandom_range(0, 99) == 0));
            end
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        check("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
